// File: rtl/line_loader.sv
// Serial-to-parallel line feeder for the permutation datapath: assembles MEMSIZE bits LSB first,
// hands the line over with init_line/core_start and counts NUM_LINES lines per job.
module line_loader #(
   parameter int unsigned SIZE      = 5,
   parameter int unsigned MEMSIZE   = SIZE * SIZE,
   parameter int unsigned NUM_LINES = 4,
   parameter int unsigned CNTW      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               in_bit,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               core_done,
   output logic [MEMSIZE-1:0] line,
   output logic               init_line,
   output logic               core_start,
   output logic               busy,
   output logic [CNTW-1:0]    line_cnt,
   output logic               job_done
);

   localparam int unsigned BW = $clog2(MEMSIZE);

   typedef enum logic [2:0] {StIdle, StShift, StLoad, StStart, StWait} state_e;

   state_e             state_q, state_d;
   logic [BW-1:0]      bitcnt;
   logic [MEMSIZE-1:0] shreg;
   logic               accept;
   logic               last_bit;
   logic [CNTW-1:0]    cnt_inc;
   logic               job_end;

   assign accept   = (state_q == StShift) && in_valid;
   assign last_bit = accept && (bitcnt == BW'(MEMSIZE - 1));
   assign cnt_inc  = line_cnt + CNTW'(1);
   assign job_end  = (cnt_inc == CNTW'(NUM_LINES));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StShift;
         StShift: if (last_bit) state_d = StLoad;
         StLoad:  state_d = StStart;
         StStart: state_d = StWait;
         StWait:  if (core_done) state_d = job_end ? StIdle : StShift;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the registered state only
   always_comb begin
      in_ready   = 1'b0;
      init_line  = 1'b0;
      core_start = 1'b0;
      busy       = 1'b1;
      unique case (state_q)
         StIdle:  busy       = 1'b0;
         StShift: in_ready   = 1'b1;
         StLoad:  init_line  = 1'b1;
         StStart: core_start = 1'b1;
         StWait:  ;
         default: busy       = 1'b0;
      endcase
   end

   // Datapath: bit counter, shift register, captured line, line counter, job pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bitcnt   <= '0;
         shreg    <= '0;
         line     <= '0;
         line_cnt <= '0;
         job_done <= 1'b0;
      end else begin
         job_done <= 1'b0;
         if ((state_q == StIdle) && start) begin
            bitcnt   <= '0;
            line_cnt <= '0;
         end
         if (accept) begin
            shreg[bitcnt] <= in_bit;
            if (last_bit) begin
               // Last bit bypasses shreg so line is complete on this same edge
               line   <= {in_bit, shreg[MEMSIZE-2:0]};
               bitcnt <= '0;
            end else begin
               bitcnt <= bitcnt + BW'(1);
            end
         end
         if ((state_q == StWait) && core_done) begin
            line_cnt <= cnt_inc;
            job_done <= job_end;
         end
      end
   end

endmodule

// File: tb/tb_line_loader.sv
// Bench for line_loader: two instances (NUM_LINES=1 and 4) share one stimulus stream and are
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_line_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, in_bit = 1'b0, in_valid = 1'b0, core_done = 1'b0;
   logic        in_ready[2], init_line[2], core_start[2], busy[2], job_done[2];
   logic [24:0] line[2];
   logic [7:0]  line_cnt[2];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   line_loader #(.NUM_LINES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .in_bit(in_bit), .in_valid(in_valid),
      .in_ready(in_ready[0]), .core_done(core_done), .line(line[0]),
      .init_line(init_line[0]), .core_start(core_start[0]), .busy(busy[0]),
      .line_cnt(line_cnt[0]), .job_done(job_done[0])
   );

   line_loader #(.NUM_LINES(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .in_bit(in_bit), .in_valid(in_valid),
      .in_ready(in_ready[1]), .core_done(core_done), .line(line[1]),
      .init_line(init_line[1]), .core_start(core_start[1]), .busy(busy[1]),
      .line_cnt(line_cnt[1]), .job_done(job_done[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 collecting, 2 handing over, 3 starting core, 4 awaiting core
   int          nl[2] = '{1, 4};
   int          ph[2] = '{0, 0};
   int          k[2] = '{0, 0};
   int          mcnt[2] = '{0, 0};
   logic [24:0] acc[2] = '{25'd0, 25'd0};
   logic [24:0] mline[2] = '{25'd0, 25'd0};
   bit          mjd[2] = '{1'b0, 1'b0};

   initial begin
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!rst) begin
               ph[i] = 0; k[i] = 0; mcnt[i] = 0; acc[i] = '0; mline[i] = '0; mjd[i] = 0;
            end else begin
               mjd[i] = 0;
               case (ph[i])
                  0: if (start) begin mcnt[i] = 0; k[i] = 0; ph[i] = 1; end
                  1: if (in_valid) begin
                     acc[i][k[i]] = in_bit;
                     if (k[i] == 24) begin
                        mline[i] = acc[i]; k[i] = 0; ph[i] = 2;
                     end else k[i]++;
                  end
                  2: ph[i] = 3;
                  3: ph[i] = 4;
                  default: if (core_done) begin
                     mcnt[i] = (mcnt[i] + 1) % 256;
                     if (mcnt[i] == nl[i]) begin ph[i] = 0; mjd[i] = 1; end
                     else ph[i] = 1;
                  end
               endcase
            end
         end
         #1;
         for (int i = 0; i < 2; i++) begin
            check($sformatf("m%0d.in_ready", i), in_ready[i], ph[i] == 1);
            check($sformatf("m%0d.init_line", i), init_line[i], ph[i] == 2);
            check($sformatf("m%0d.core_start", i), core_start[i], ph[i] == 3);
            check($sformatf("m%0d.busy", i), busy[i], ph[i] != 0);
            check($sformatf("m%0d.line", i), line[i], mline[i]);
            check($sformatf("m%0d.line_cnt", i), line_cnt[i], mcnt[i]);
            check($sformatf("m%0d.job_done", i), job_done[i], mjd[i]);
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic restart();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic send_line(input logic [24:0] v, input logic [24:0] prev, input bit stall,
                            input bit abuse);
      for (int b = 0; b < 25; b++) begin
         in_valid  = 1'b1;
         in_bit    = v[b];
         start     = abuse && (b == 5);
         core_done = abuse && (b == 5);
         cyc();
         start     = 1'b0;
         core_done = 1'b0;
         if (b == 10) begin
            check("stable_line1", line[0], prev);
            check("stable_line4", line[1], prev);
         end
         // Stalls placed before the final bit so the handover timing stays observable
         if (stall && (b == 0 || b == 12 || b == 23)) begin
            in_valid = 1'b0;
            for (int s = 0; s < 3; s++) begin
               cyc();
               check("ready_in_stall", in_ready[1], 1);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic handoff(input logic [24:0] v, input int hold, input int cnt4);
      check("init_line_n1", {init_line[0], init_line[1], core_start[1]}, 3'b110);
      cyc();
      check("core_start_n2", {init_line[1], core_start[0], core_start[1]}, 3'b011);
      cyc();
      check("wait_ready", {in_ready[0], in_ready[1], busy[1]}, 3'b001);
      check("line_dut1", line[0], v);
      check("line_dut4", line[1], v);
      core_done = 1'b1;
      cyc();
      check("job_done_dut1", job_done[0], 1);
      check("cnt_dut1", line_cnt[0], 1);
      check("cnt_dut4", line_cnt[1], cnt4);
      check("job_done_dut4", job_done[1], cnt4 == 4);
      check("ready_after_done", in_ready[1], cnt4 != 4);
      repeat (hold - 1) cyc();
      core_done = 1'b0;
      cyc();
      check("cnt_dut4_held", line_cnt[1], cnt4);
   endtask

   initial begin
      #2 rst = 1'b0;
      cyc(2);
      rst = 1'b1;
      cyc();
      check("rst_line", line[1], 0);
      check("rst_busy", {busy[0], busy[1]}, 0);

      // Reset in the middle of a line
      restart();
      for (int b = 0; b < 10; b++) begin
         in_valid = 1'b1; in_bit = 1'b1; cyc();
      end
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("midrst_outs", {in_ready[1], init_line[1], core_start[1], busy[1], job_done[1]}, 0);
      check("midrst_cnt", line_cnt[1], 0);
      check("midrst_line", line[1], 0);
      cyc(2);
      rst = 1'b1;
      cyc();

      // Job A: dut1 completes a job per line, dut4 counts four lines
      restart();
      send_line(25'h1A55A5A, 25'h0, 1'b0, 1'b0);
      handoff(25'h1A55A5A, 1, 1);
      restart();
      send_line(25'h1A55A5A, 25'h1A55A5A, 1'b1, 1'b0);
      handoff(25'h1A55A5A, 1, 2);
      restart();
      send_line(25'h0AAAAAA, 25'h1A55A5A, 1'b0, 1'b1);
      handoff(25'h0AAAAAA, 5, 3);
      restart();
      send_line(25'h1FFFFFF, 25'h0AAAAAA, 1'b0, 1'b0);
      handoff(25'h1FFFFFF, 1, 4);
      check("idle_after_job", busy[1], 0);
      cyc(2);
      check("cnt_held_idle", line_cnt[1], 4);

      // Job B: the four directed lines
      restart();
      send_line(25'h0000001, 25'h1FFFFFF, 1'b0, 1'b0);
      handoff(25'h0000001, 1, 1);
      restart();
      send_line(25'h1000000, 25'h0000001, 1'b0, 1'b0);
      handoff(25'h1000000, 1, 2);
      restart();
      send_line(25'h1FFFFFF, 25'h1000000, 1'b1, 1'b0);
      handoff(25'h1FFFFFF, 1, 3);
      restart();
      send_line(25'h0AAAAAA, 25'h1FFFFFF, 1'b0, 1'b0);
      handoff(25'h0AAAAAA, 1, 4);
      cyc(3);
      check("final_idle", {busy[0], busy[1], job_done[1]}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
